// File: rtl/pipe_mux_pkg.sv
// Shared definitions for the pipelined N-way mux: parameter limits and select width.
package pipe_mux_pkg;

    localparam int WIDTH_MIN  = 1;
    localparam int WIDTH_MAX  = 64;
    localparam int N_IN_MIN   = 2;
    localparam int N_IN_MAX   = 8;
    localparam int STAGES_MIN = 1;
    localparam int STAGES_MAX = 4;

    // max(1, ceil(log2(n))), bounded loop so it stays a legal constant function
    function automatic int sel_width(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 8; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/pipe_mux_stage.sv
// One pipeline slot holding {valid, err, data}; clear wins over advance.
module pipe_mux_stage
    import pipe_mux_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             flush,
    input  logic             advance,
    input  logic             d_valid,
    input  logic             d_err,
    input  logic [WIDTH-1:0] d_data,
    output logic             q_valid,
    output logic             q_err,
    output logic [WIDTH-1:0] q_data
);

    logic [WIDTH+1:0] stage_reg;

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            stage_reg <= '0;
        end else if (advance) begin
            stage_reg <= {d_valid, d_err, d_data};
        end
    end

    assign q_valid = stage_reg[WIDTH+1];
    assign q_err   = stage_reg[WIDTH];
    assign q_data  = stage_reg[WIDTH-1:0];

endmodule

// File: rtl/pipe_mux_n.sv
// N-input mux followed by a STAGES-deep stall/flush pipeline; outputs come straight from the last slot.
module pipe_mux_n
    import pipe_mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int N_IN   = 4,
    parameter int STAGES = 1,
    localparam int SEL_W = sel_width(N_IN)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [N_IN*WIDTH-1:0] data_i,
    input  logic [SEL_W-1:0]      select_i,
    input  logic                  valid_i,
    input  logic                  stall_i,
    input  logic                  flush_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  valid_o,
    output logic                  sel_err_o
);

    localparam logic [SEL_W:0] N_IN_CMP = (SEL_W + 1)'(N_IN);

    logic [WIDTH-1:0] chan [N_IN];

    logic             st_valid [STAGES+1];
    logic             st_err   [STAGES+1];
    logic [WIDTH-1:0] st_data  [STAGES+1];

    logic             mux_valid;
    logic             mux_err;
    logic [WIDTH-1:0] mux_data;
    logic             advance;

    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_chan
            assign chan[gi] = data_i[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Out-of-range selects fall back to channel 0 and flag the beat; bubbles carry all zeros.
    always_comb begin
        mux_valid = valid_i;
        mux_err   = 1'b0;
        mux_data  = chan[0];
        for (int k = 1; k < N_IN; k++) begin
            if (select_i == SEL_W'(k)) begin
                mux_data = chan[k];
            end
        end
        if ({1'b0, select_i} >= N_IN_CMP) begin
            mux_err = 1'b1;
        end
        if (!valid_i) begin
            mux_valid = 1'b0;
            mux_err   = 1'b0;
            mux_data  = '0;
        end
    end

    assign advance     = ~stall_i;
    assign st_valid[0] = mux_valid;
    assign st_err[0]   = mux_err;
    assign st_data[0]  = mux_data;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
            pipe_mux_stage #(
                .WIDTH (WIDTH)
            ) u_stage (
                .clk     (clk_i),
                .srst    (rst_i),
                .flush   (flush_i),
                .advance (advance),
                .d_valid (st_valid[gi]),
                .d_err   (st_err[gi]),
                .d_data  (st_data[gi]),
                .q_valid (st_valid[gi+1]),
                .q_err   (st_err[gi+1]),
                .q_data  (st_data[gi+1])
            );
        end
    endgenerate

    // Every path into a slot zeroes data and err when invalid, so no output gating is needed.
    assign valid_o   = st_valid[STAGES];
    assign sel_err_o = st_err[STAGES];
    assign data_o    = st_data[STAGES];

endmodule

// File: tb/tb_pipe_mux_n.sv
// Bench for pipe_mux_n: seven parameter variants driven from one stimulus bus and checked against a delay-line model.
module tb_pipe_mux_n;

    localparam int NDUT = 7;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        stall;
    logic        flush;
    logic [2:0]  sel;
    logic [63:0] chan [8];

    logic [127:0] din0;
    logic [95:0]  din1;
    logic [15:0]  din3;
    logic [511:0] din4;
    logic [31:0]  din5;

    logic [31:0] dq0, dq1, dq2;
    logic [7:0]  dq3;
    logic [63:0] dq4, dq6;
    logic [15:0] dq5;

    logic        o_v [NDUT];
    logic        o_e [NDUT];
    logic [63:0] o_d [NDUT];

    // model: per-variant slots indexed by age, output is the oldest slot in use
    logic        mv [NDUT][4];
    logic        me [NDUT][4];
    logic [63:0] md [NDUT][4];

    int tests;
    int fails;

    assign din0 = {chan[3][31:0], chan[2][31:0], chan[1][31:0], chan[0][31:0]};
    assign din1 = {chan[2][31:0], chan[1][31:0], chan[0][31:0]};
    assign din3 = {chan[1][7:0], chan[0][7:0]};
    assign din4 = {chan[7], chan[6], chan[5], chan[4], chan[3], chan[2], chan[1], chan[0]};
    assign din5 = {chan[1][15:0], chan[0][15:0]};

    assign o_d[0] = {32'b0, dq0};
    assign o_d[1] = {32'b0, dq1};
    assign o_d[2] = {32'b0, dq2};
    assign o_d[3] = {56'b0, dq3};
    assign o_d[4] = dq4;
    assign o_d[5] = {48'b0, dq5};
    assign o_d[6] = dq6;

    pipe_mux_n #(.WIDTH(32), .N_IN(4), .STAGES(2)) u_dut0 (
        .clk_i(clk), .rst_i(rst), .data_i(din0), .select_i(sel[1:0]), .valid_i(valid),
        .stall_i(stall), .flush_i(flush), .data_o(dq0), .valid_o(o_v[0]), .sel_err_o(o_e[0]));
    pipe_mux_n #(.WIDTH(32), .N_IN(3), .STAGES(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .data_i(din1), .select_i(sel[1:0]), .valid_i(valid),
        .stall_i(stall), .flush_i(flush), .data_o(dq1), .valid_o(o_v[1]), .sel_err_o(o_e[1]));
    pipe_mux_n #(.WIDTH(32), .N_IN(4), .STAGES(3)) u_dut2 (
        .clk_i(clk), .rst_i(rst), .data_i(din0), .select_i(sel[1:0]), .valid_i(valid),
        .stall_i(stall), .flush_i(flush), .data_o(dq2), .valid_o(o_v[2]), .sel_err_o(o_e[2]));
    pipe_mux_n #(.WIDTH(8), .N_IN(2), .STAGES(1)) u_dut3 (
        .clk_i(clk), .rst_i(rst), .data_i(din3), .select_i(sel[0]), .valid_i(valid),
        .stall_i(stall), .flush_i(flush), .data_o(dq3), .valid_o(o_v[3]), .sel_err_o(o_e[3]));
    pipe_mux_n #(.WIDTH(64), .N_IN(8), .STAGES(4)) u_dut4 (
        .clk_i(clk), .rst_i(rst), .data_i(din4), .select_i(sel), .valid_i(valid),
        .stall_i(stall), .flush_i(flush), .data_o(dq4), .valid_o(o_v[4]), .sel_err_o(o_e[4]));
    pipe_mux_n #(.WIDTH(16), .N_IN(2), .STAGES(4)) u_dut5 (
        .clk_i(clk), .rst_i(rst), .data_i(din5), .select_i(sel[0]), .valid_i(valid),
        .stall_i(stall), .flush_i(flush), .data_o(dq5), .valid_o(o_v[5]), .sel_err_o(o_e[5]));
    pipe_mux_n #(.WIDTH(64), .N_IN(8), .STAGES(1)) u_dut6 (
        .clk_i(clk), .rst_i(rst), .data_i(din4), .select_i(sel), .valid_i(valid),
        .stall_i(stall), .flush_i(flush), .data_o(dq6), .valid_o(o_v[6]), .sel_err_o(o_e[6]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int pw(input int d);
        case (d)
            3:       return 8;
            4, 6:    return 64;
            5:       return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int pn(input int d);
        case (d)
            1:       return 3;
            3, 5:    return 2;
            4, 6:    return 8;
            default: return 4;
        endcase
    endfunction

    function automatic int ps(input int d);
        case (d)
            0:       return 2;
            2:       return 3;
            4, 5:    return 4;
            default: return 1;
        endcase
    endfunction

    function automatic int selw(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got v/e/data %h, expected %h", name, act, exp);
        end
    endtask

    // What the mux should deliver for variant d given the current inputs.
    task automatic ref_beat(input int d, output logic v, output logic e, output logic [63:0] data);
        int          s;
        logic [63:0] mask;
        mask = (pw(d) == 64) ? {64{1'b1}} : ((64'd1 << pw(d)) - 64'd1);
        s    = int'(sel) % (1 << selw(pn(d)));
        v = 1'b0;
        e = 1'b0;
        data = '0;
        if (valid) begin
            v = 1'b1;
            if (s < pn(d)) begin
                data = chan[s] & mask;
            end else begin
                data = chan[0] & mask;
                e    = 1'b1;
            end
        end
    endtask

    task automatic model_step();
        logic        v, e;
        logic [63:0] data;
        for (int d = 0; d < NDUT; d++) begin
            if (rst || flush) begin
                for (int k = 0; k < 4; k++) begin
                    mv[d][k] = 1'b0;
                    me[d][k] = 1'b0;
                    md[d][k] = '0;
                end
            end else if (!stall) begin
                for (int k = 3; k > 0; k--) begin
                    mv[d][k] = mv[d][k-1];
                    me[d][k] = me[d][k-1];
                    md[d][k] = md[d][k-1];
                end
                ref_beat(d, v, e, data);
                mv[d][0] = v;
                me[d][0] = e;
                md[d][0] = data;
            end
        end
    endtask

    // One clock: update the model with the inputs the DUT sampled, then compare every variant.
    task automatic cycle();
        int l;
        @(posedge clk);
        model_step();
        #1;
        for (int d = 0; d < NDUT; d++) begin
            l = ps(d) - 1;
            check($sformatf("model dut%0d", d), {o_v[d], o_e[d], o_d[d]}, {mv[d][l], me[d][l], md[d][l]});
        end
    endtask

    task automatic chk(input string name, input int d, input logic v, input logic e, input logic [63:0] data);
        check(name, {o_v[d], o_e[d], o_d[d]}, {v, e, data});
    endtask

    typedef struct {
        logic        rst;
        logic        valid;
        logic        stall;
        logic [2:0]  sel;
        logic [63:0] c0;
        int          dut;
        logic        ev;
        logic        ee;
        logic [63:0] ed;
    } vec_t;

    vec_t vecs [15];

    initial begin
        tests = 0;
        fails = 0;
        for (int d = 0; d < NDUT; d++) begin
            for (int k = 0; k < 4; k++) begin
                mv[d][k] = 1'b0;
                me[d][k] = 1'b0;
                md[d][k] = '0;
            end
        end
        rst = 1'b1; valid = 1'b0; stall = 1'b0; flush = 1'b0; sel = 3'd0;
        for (int k = 0; k < 8; k++) chan[k] = 64'(k + 1) * 64'h11;

        //          rst   v     stall sel   c0      dut ev    ee    ed
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 3'd0, 64'h11, 0, 1'b0, 1'b0, 64'h0};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 3'd0, 64'h11, 0, 1'b0, 1'b0, 64'h0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 3'd1, 64'h11, 0, 1'b1, 1'b0, 64'h11};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 3'd2, 64'h11, 0, 1'b1, 1'b0, 64'h22};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 3'd3, 64'h11, 0, 1'b1, 1'b0, 64'h33};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 3'd0, 64'h11, 0, 1'b1, 1'b0, 64'h44};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 3'd0, 64'h11, 0, 1'b0, 1'b0, 64'h0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 3'd3, 64'hAA, 1, 1'b1, 1'b1, 64'hAA};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 3'd0, 64'hAA, 1, 1'b0, 1'b0, 64'h0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 3'd2, 64'hAA, 1, 1'b1, 1'b0, 64'h33};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 3'd7, 64'hAA, 3, 1'b1, 1'b0, 64'h22};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 3'd5, 64'hAA, 6, 1'b1, 1'b0, 64'h66};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 3'd1, 64'hAA, 0, 1'b1, 1'b0, 64'h44};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 3'd0, 64'hAA, 0, 1'b1, 1'b0, 64'h22};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 3'd0, 64'hAA, 0, 1'b0, 1'b0, 64'h0};

        #2;
        for (int i = 0; i < 15; i++) begin
            rst = vecs[i].rst; valid = vecs[i].valid; stall = vecs[i].stall;
            sel = vecs[i].sel; chan[0] = vecs[i].c0;
            cycle();
            chk($sformatf("vec%0d", i), vecs[i].dut, vecs[i].ev, vecs[i].ee, vecs[i].ed);
        end

        // stall for two cycles after B enters a 3-deep pipe
        sel = 3'd0; stall = 1'b0;
        flush = 1'b1; valid = 1'b0; cycle(); flush = 1'b0;
        valid = 1'b1; chan[0] = 64'hA1; cycle();
        chan[0] = 64'hB2; cycle();
        stall = 1'b1; chan[0] = 64'hEE; cycle(); chk("stall hold 1", 2, 1'b0, 1'b0, 64'h0);
        cycle(); chk("stall hold 2", 2, 1'b0, 1'b0, 64'h0);
        stall = 1'b0; chan[0] = 64'hC3; cycle(); chk("stall beat A", 2, 1'b1, 1'b0, 64'hA1);
        valid = 1'b0; cycle(); chk("stall beat B", 2, 1'b1, 1'b0, 64'hB2);
        cycle(); chk("stall beat C", 2, 1'b1, 1'b0, 64'hC3);
        cycle(); chk("stall tail 1", 2, 1'b0, 1'b0, 64'h0);
        cycle(); chk("stall tail 2", 2, 1'b0, 1'b0, 64'h0);

        // flush together with stall kills three beats in flight
        valid = 1'b1; chan[0] = 64'h51; cycle();
        chan[0] = 64'h52; cycle();
        chan[0] = 64'h53; cycle(); chk("pre-flush head", 2, 1'b1, 1'b0, 64'h51);
        flush = 1'b1; stall = 1'b1; chan[0] = 64'h54; cycle(); chk("flush+stall", 2, 1'b0, 1'b0, 64'h0);
        flush = 1'b0; stall = 1'b0; valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(); chk($sformatf("post-flush %0d", i), 2, 1'b0, 1'b0, 64'h0);
        end

        // reset pulse mid-stream
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chan[0] = 64'h61 + 64'(i); cycle();
        end
        rst = 1'b1; chan[0] = 64'h99; cycle(); chk("mid reset dut0", 0, 1'b0, 1'b0, 64'h0);
        chk("mid reset dut4", 4, 1'b0, 1'b0, 64'h0);
        rst = 1'b0; chan[0] = 64'h70; cycle(); chk("post reset 0", 0, 1'b0, 1'b0, 64'h0);
        valid = 1'b0; cycle(); chk("post reset beat", 0, 1'b1, 1'b0, 64'h70);
        cycle(); chk("post reset tail", 0, 1'b0, 1'b0, 64'h0);

        // randomized traffic across all variants
        for (int i = 0; i < 10000; i++) begin
            rst   = ($urandom_range(0, 149) == 0);
            flush = ($urandom_range(0, 39) == 0);
            stall = ($urandom_range(0, 4) == 0);
            valid = ($urandom_range(0, 3) != 0);
            sel   = 3'($urandom);
            for (int k = 0; k < 8; k++) chan[k] = {$urandom, $urandom};
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_mux_n.md
PIPE_MUX_N -- requirements
Module: pipe_mux_n

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel in bits; legal range 1..64.
REQ-002 Parameter N_IN, default 4, number of input channels; legal range 2..8.
REQ-003 Parameter STAGES, default 1, pipeline depth from input to output; legal range 1..4.
REQ-004 Derived localparam SEL_W = max(1, ceil(log2(N_IN))); it is not overridable.
REQ-005 clk_i  input  1  single clock; all state updates on rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 data_i  input  N_IN*WIDTH  flattened channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 select_i  input  SEL_W  channel index, sampled with valid_i.
REQ-009 valid_i  input  1  input beat present this cycle.
REQ-010 stall_i  input  1  hold all stages, ignore inputs.
REQ-011 flush_i  input  1  kill every beat in flight.
REQ-012 data_o  output  WIDTH  selected data after STAGES cycles.
REQ-013 valid_o  output  1  data_o carries a live beat.
REQ-014 sel_err_o  output  1  the beat on data_o was captured with select_i >= N_IN.

Function
REQ-015 Each stage SHALL hold {valid, err, data}; stage 0 captures the mux result, and stage s captures stage s-1 when advancing.
REQ-016 Mux result SHALL be data_i channel select_i when select_i < N_IN, otherwise channel 0 with err=1.
REQ-017 When stall_i=0 and flush_i=0, every stage SHALL advance, giving latency exactly STAGES cycles from valid_i to valid_o.
REQ-018 valid_i=0 while advancing SHALL insert a bubble: valid=0, err=0, data=0.
REQ-019 stall_i=1 with flush_i=0 SHALL hold all stages unchanged; the input beat that cycle is dropped, and upstream must hold it.
REQ-020 flush_i=1 SHALL clear valid, err and data of every stage at the next edge, regardless of stall_i and valid_i; the input that cycle is discarded.
REQ-021 Priority SHALL be rst_i > flush_i > stall_i > advance.
REQ-022 data_o and sel_err_o SHALL be 0 whenever valid_o=0.
REQ-023 Outputs SHALL be driven directly from the last stage registers, with no combinational path from any input to any output.
REQ-024 No stage bubble-collapse: a stall SHALL freeze bubbles as well as live beats.

Reset
REQ-025 rst_i=1 at a rising edge SHALL clear every stage to valid=0, err=0, data=0, so data_o=0, valid_o=0 and sel_err_o=0 on the following cycle.
REQ-026 Reset mid-stream SHALL discard all in-flight beats; no beat captured before the reset edge appears afterwards.
REQ-027 The first beat accepted after reset SHALL be one presented with rst_i=0.

Structure
REQ-028 Shared package pipe_mux_pkg SHALL hold the SEL_W computation function and the legal-range limits of the parameters.
REQ-029 One sub-module pipe_mux_stage (WIDTH+2-bit register with advance/flush/reset controls) SHALL be instantiated STAGES times via generate.
REQ-030 The mux SHALL be a purely combinational block inside the top level, not latch-inferring, with every select value defined.

Verification
REQ-031 WIDTH=32, N_IN=4, STAGES=2; beats sel=0..3 with data_i channels 0x11,0x22,0x33,0x44 on consecutive cycles -> valid_o high on cycles 2..5 with data_o 0x11,0x22,0x33,0x44, sel_err_o=0.
REQ-032 N_IN=3, STAGES=1; select_i=3 with channel 0 = 0xAA -> next cycle data_o=0xAA, valid_o=1, sel_err_o=1.
REQ-033 STAGES=3; beats A,B,C in, stall_i high 2 cycles after B enters -> outputs frozen 2 cycles, then A,B,C each emerge exactly once in order, and the inputs offered during the stall never appear.
REQ-034 STAGES=3; 3 beats in flight, flush_i=1 together with stall_i=1 -> next cycle valid_o=0, and no flushed beat appears in the following 4 cycles.
REQ-035 Stream of beats, rst_i pulsed 1 cycle mid-stream -> valid_o=0 and data_o=0 the next cycle; only post-reset beats appear, each after STAGES cycles.
REQ-036 Random stimulus against a reference queue model, all parameter corners (N_IN=2 and 8, STAGES=1 and 4) -> zero mismatches over 10k cycles.
